nand_chain_arbiter: RTL and testbench

NAND_CHAIN_ARBITER -- requirements
Module: nand_chain_arbiter

---
 rtl/nand_chain_pkg.sv | 13 +
 rtl/nand_chain_datapath.sv | 23 ++
 rtl/nand_chain_arbiter.sv | 159 +++++++++++++++
 tb/tb_nand_chain_arbiter.sv | 303 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/nand_chain_pkg.sv
// Shared constants and FSM state encoding for the cascaded-NAND arbiter.
package nand_chain_pkg;

    localparam int DATA_WIDTH = 8;
    localparam int NUM_REQ    = 3;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        EXEC = 2'd1,
        RESP = 2'd2
    } state_e;

endpackage

// File: rtl/nand_chain_datapath.sv
// Two-stage bitwise NAND cascade: d = ~(a & b), e = ~(c & d).
module nand_chain_datapath
    import nand_chain_pkg::*;
#(
    parameter int WIDTH = DATA_WIDTH
) (
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic [WIDTH-1:0] c,
    output logic [WIDTH-1:0] d,
    output logic [WIDTH-1:0] e
);

    logic [WIDTH-1:0] d_s;

    // Second stage consumes the first-stage result directly
    always_comb begin
        d_s = ~(a & b);
        d   = d_s;
        e   = ~(c & d_s);
    end

endmodule

// File: rtl/nand_chain_arbiter.sv
// Round-robin arbiter sharing one NAND-cascade datapath among N_REQ requesters
// through an IDLE -> EXEC -> RESP transaction.
module nand_chain_arbiter
    import nand_chain_pkg::*;
#(
    parameter int WIDTH = DATA_WIDTH,
    parameter int N_REQ = NUM_REQ
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic [N_REQ-1:0]       req_valid,
    output logic [N_REQ-1:0]       req_ready,
    input  logic [N_REQ*WIDTH-1:0] req_a,
    input  logic [N_REQ*WIDTH-1:0] req_b,
    input  logic [N_REQ*WIDTH-1:0] req_c,
    output logic                   resp_valid,
    input  logic                   resp_ready,
    output logic [WIDTH-1:0]       resp_d,
    output logic [WIDTH-1:0]       resp_e,
    output logic [1:0]             resp_id,
    output logic                   busy
);

    localparam logic [1:0] LAST_RST = 2'(N_REQ - 1);

    state_e           state_q, state_d;
    logic [1:0]       last_grant_q, last_grant_d;
    logic [WIDTH-1:0] a_q, a_d, b_q, b_d, c_q, c_d;
    logic [WIDTH-1:0] d_q, d_d, e_q, e_d;
    logic [1:0]       id_q, id_d;
    logic             valid_q, valid_d;
    logic             busy_q, busy_d;
    logic [2:0]       pick_s;
    logic [N_REQ-1:0] grant_s;
    logic [WIDTH-1:0] sel_a_s, sel_b_s, sel_c_s;
    logic [WIDTH-1:0] dp_d_s, dp_e_s;

    // Returns {found, index}: first valid requester after 'last', wrapping around.
    function automatic logic [2:0] rr_pick(input logic [N_REQ-1:0] valid,
                                           input logic [1:0]       last);
        logic [2:0] res;
        logic [1:0] cand;
        res = 3'b000;
        for (int k = N_REQ; k >= 1; k--) begin
            cand = 2'((int'(last) + k) % N_REQ);
            if (valid[cand]) begin
                res = {1'b1, cand};
            end else begin
                res = res;
            end
        end
        return res;
    endfunction

    nand_chain_datapath #(.WIDTH(WIDTH)) u_datapath (
        .a (a_q),
        .b (b_q),
        .c (c_q),
        .d (dp_d_s),
        .e (dp_e_s)
    );

    // Grant selection, operand capture and next-state logic
    always_comb begin
        pick_s       = rr_pick(req_valid, last_grant_q);
        grant_s      = '0;
        state_d      = state_q;
        last_grant_d = last_grant_q;
        a_d          = a_q;
        b_d          = b_q;
        c_d          = c_q;
        d_d          = d_q;
        e_d          = e_q;
        id_d         = id_q;
        valid_d      = valid_q;
        busy_d       = busy_q;
        sel_a_s      = '0;
        sel_b_s      = '0;
        sel_c_s      = '0;
        for (int i = 0; i < N_REQ; i++) begin
            sel_a_s = sel_a_s | (req_a[i*WIDTH +: WIDTH] & {WIDTH{pick_s[1:0] == 2'(i)}});
            sel_b_s = sel_b_s | (req_b[i*WIDTH +: WIDTH] & {WIDTH{pick_s[1:0] == 2'(i)}});
            sel_c_s = sel_c_s | (req_c[i*WIDTH +: WIDTH] & {WIDTH{pick_s[1:0] == 2'(i)}});
        end
        case (state_q)
            IDLE: begin
                if (pick_s[2]) begin
                    grant_s[pick_s[1:0]] = 1'b1;
                    last_grant_d         = pick_s[1:0];
                    id_d                 = pick_s[1:0];
                    a_d                  = sel_a_s;
                    b_d                  = sel_b_s;
                    c_d                  = sel_c_s;
                    busy_d               = 1'b1;
                    state_d              = EXEC;
                end else begin
                    state_d = IDLE;
                end
            end
            EXEC: begin
                d_d     = dp_d_s;
                e_d     = dp_e_s;
                valid_d = 1'b1;
                state_d = RESP;
            end
            RESP: begin
                if (resp_ready) begin
                    valid_d = 1'b0;
                    busy_d  = 1'b0;
                    state_d = IDLE;
                end else begin
                    state_d = RESP;
                end
            end
            default: begin
                valid_d = 1'b0;
                busy_d  = 1'b0;
                state_d = IDLE;
            end
        endcase
    end

    // Reset forces the grant low even while requesters are already asserting valid
    assign req_ready = grant_s & {N_REQ{rst_n}};

    // State, operand and result registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= IDLE;
            last_grant_q <= LAST_RST;
            a_q          <= '0;
            b_q          <= '0;
            c_q          <= '0;
            d_q          <= '0;
            e_q          <= '0;
            id_q         <= 2'd0;
            valid_q      <= 1'b0;
            busy_q       <= 1'b0;
        end else begin
            state_q      <= state_d;
            last_grant_q <= last_grant_d;
            a_q          <= a_d;
            b_q          <= b_d;
            c_q          <= c_d;
            d_q          <= d_d;
            e_q          <= e_d;
            id_q         <= id_d;
            valid_q      <= valid_d;
            busy_q       <= busy_d;
        end
    end

    assign resp_valid = valid_q;
    assign resp_d     = d_q;
    assign resp_e     = e_q;
    assign resp_id    = id_q;
    assign busy       = busy_q;

endmodule

// File: tb/tb_nand_chain_arbiter.sv
// Self-checking bench for nand_chain_arbiter against a transaction-level reference model.
module tb_nand_chain_arbiter;

    localparam int W = 8;
    localparam int N = 3;

    logic           clk = 1'b0;
    logic           rst_n = 1'b0;
    logic [N-1:0]   req_valid = '0;
    logic [N-1:0]   req_ready;
    logic [N*W-1:0] req_a = '0, req_b = '0, req_c = '0;
    logic           resp_valid;
    logic           resp_ready = 1'b0;
    logic [W-1:0]   resp_d, resp_e;
    logic [1:0]     resp_id;
    logic           busy;

    int n_checks = 0;
    int n_fail   = 0;

    // Model: one outstanding transaction, aged in cycles since its grant edge
    bit           m_pend;
    int           m_age;
    int           m_last;
    int           m_id;
    logic [W-1:0] m_d, m_e;
    logic [N-1:0] exp_ready;
    bit           exp_rv, exp_busy;

    nand_chain_arbiter #(.WIDTH(W), .N_REQ(N)) dut (
        .clk(clk), .rst_n(rst_n),
        .req_valid(req_valid), .req_ready(req_ready),
        .req_a(req_a), .req_b(req_b), .req_c(req_c),
        .resp_valid(resp_valid), .resp_ready(resp_ready),
        .resp_d(resp_d), .resp_e(resp_e), .resp_id(resp_id),
        .busy(busy)
    );

    always #5 clk = ~clk;

    function automatic int rr_ref(logic [N-1:0] v, int last);
        for (int k = 1; k <= N; k++) begin
            int idx;
            idx = (last + k) % N;
            if (((v >> idx) & 3'd1) != 3'd0) return idx;
        end
        return -1;
    endfunction

    function automatic logic [W-1:0] opnd(logic [N*W-1:0] bus, int i);
        return bus[i*W +: W];
    endfunction

    function automatic int onehot_idx(logic [N-1:0] v);
        for (int i = 0; i < N; i++) if (v == (3'd1 << i)) return i;
        return -1;
    endfunction

    task automatic model_reset();
        m_pend = 1'b0;
        m_age  = 0;
        m_last = N - 1;
    endtask

    task automatic model_eval();
        int g;
        exp_ready = '0;
        exp_rv    = 1'b0;
        exp_busy  = m_pend;
        if (!m_pend) begin
            g = rr_ref(req_valid, m_last);
            if (g >= 0) exp_ready = N'(1) << g;
        end else begin
            exp_rv = (m_age >= 2);
        end
    endtask

    task automatic tick();
        int g;
        @(posedge clk);
        if (!rst_n) begin
            model_reset();
        end else if (!m_pend) begin
            g = rr_ref(req_valid, m_last);
            if (g >= 0) begin
                m_pend = 1'b1;
                m_age  = 1;
                m_id   = g;
                m_last = g;
                m_d    = ~(opnd(req_a, g) & opnd(req_b, g));
                m_e    = ~(opnd(req_c, g) & m_d);
            end
        end else if (m_age >= 2 && resp_ready) begin
            m_pend = 1'b0;
        end else begin
            m_age = 2;
        end
        #1;
    endtask

    task automatic set_req(int i, logic [W-1:0] a, logic [W-1:0] b, logic [W-1:0] c);
        req_a[i*W +: W] = a;
        req_b[i*W +: W] = b;
        req_c[i*W +: W] = c;
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        req_valid = '0;
        tick();
        rst_n = 1'b1;
        model_reset();
    endtask

    task automatic test_reset();
        req_valid  = 3'b111;
        resp_ready = 1'b1;
        req_a = 24'hA5C3F0; req_b = 24'h0FFF13; req_c = 24'h77EE11;
        tick();
        n_checks += 6;
        if (req_ready !== 3'b000) begin n_fail++; $display("FAIL reset_ready got %b expected 000", req_ready); end
        if (resp_valid !== 1'b0) begin n_fail++; $display("FAIL reset_resp_valid got %b expected 0", resp_valid); end
        if (busy !== 1'b0) begin n_fail++; $display("FAIL reset_busy got %b expected 0", busy); end
        if (resp_d !== 8'h00) begin n_fail++; $display("FAIL reset_resp_d got %h expected 00", resp_d); end
        if (resp_e !== 8'h00) begin n_fail++; $display("FAIL reset_resp_e got %h expected 00", resp_e); end
        if (resp_id !== 2'd0) begin n_fail++; $display("FAIL reset_resp_id got %0d expected 0", resp_id); end
        tick();
        rst_n = 1'b1;
        model_reset();
        #1;
        n_checks++;
        if (req_ready !== 3'b001) begin n_fail++; $display("FAIL reset_first_grant got %b expected 001", req_ready); end
        req_valid = '0;
    endtask

    task automatic test_single(string nm, int id, logic [W-1:0] a, logic [W-1:0] b,
                               logic [W-1:0] c, logic [W-1:0] xd, logic [W-1:0] xe);
        set_req(id, a, b, c);
        req_valid  = N'(1) << id;
        resp_ready = 1'b1;
        #1;
        n_checks++;
        if (req_ready !== (N'(1) << id)) begin n_fail++; $display("FAIL %s_grant got %b expected one-hot %0d", nm, req_ready, id); end
        tick();
        req_valid = '0;
        #1;
        n_checks += 2;
        if (resp_valid !== 1'b0) begin n_fail++; $display("FAIL %s_exec_valid got %b expected 0", nm, resp_valid); end
        if (busy !== 1'b1) begin n_fail++; $display("FAIL %s_exec_busy got %b expected 1", nm, busy); end
        tick();
        n_checks += 4;
        if (resp_valid !== 1'b1) begin n_fail++; $display("FAIL %s_latency resp_valid got %b expected 1", nm, resp_valid); end
        if (resp_d !== xd) begin n_fail++; $display("FAIL %s_d got %h expected %h", nm, resp_d, xd); end
        if (resp_e !== xe) begin n_fail++; $display("FAIL %s_e got %h expected %h", nm, resp_e, xe); end
        if (resp_id !== 2'(id)) begin n_fail++; $display("FAIL %s_id got %0d expected %0d", nm, resp_id, id); end
        tick();
        n_checks++;
        if (busy !== 1'b0) begin n_fail++; $display("FAIL %s_idle_busy got %b expected 0", nm, busy); end
    endtask

    task automatic test_fairness();
        int order[6] = '{0, 1, 2, 0, 1, 2};
        int n_gr = 0;
        int prev_cyc = -1;
        int g;
        do_reset();
        req_valid  = 3'b111;
        resp_ready = 1'b1;
        for (int cyc = 0; cyc < 18; cyc++) begin
            #1;
            g = onehot_idx(req_ready);
            if (req_ready !== 3'b000) begin
                n_checks += 2;
                if (n_gr < 6 && g !== order[n_gr]) begin n_fail++; $display("FAIL fair_order[%0d] got %0d expected %0d", n_gr, g, order[n_gr]); end
                if (prev_cyc >= 0 && cyc - prev_cyc !== 3) begin n_fail++; $display("FAIL fair_spacing got %0d expected 3", cyc - prev_cyc); end
                prev_cyc = cyc;
                n_gr++;
            end
            tick();
        end
        n_checks++;
        if (n_gr !== 6) begin n_fail++; $display("FAIL fair_count got %0d expected 6", n_gr); end
        req_valid = '0;
        tick(); tick();
    endtask

    task automatic test_backpressure();
        req_valid = 3'b111;
        for (int i = 0; i < N; i++) set_req(i, 8'($urandom), 8'($urandom), 8'($urandom));
        resp_ready = 1'b0;
        tick();
        set_req(m_id, 8'($urandom), 8'($urandom), 8'($urandom));
        tick();
        for (int cyc = 0; cyc < 5; cyc++) begin
            #1;
            n_checks += 6;
            if (resp_valid !== 1'b1) begin n_fail++; $display("FAIL bp_valid got %b expected 1", resp_valid); end
            if (resp_d !== m_d) begin n_fail++; $display("FAIL bp_d got %h expected %h", resp_d, m_d); end
            if (resp_e !== m_e) begin n_fail++; $display("FAIL bp_e got %h expected %h", resp_e, m_e); end
            if (resp_id !== 2'(m_id)) begin n_fail++; $display("FAIL bp_id got %0d expected %0d", resp_id, m_id); end
            if (req_ready !== 3'b000) begin n_fail++; $display("FAIL bp_ready got %b expected 000", req_ready); end
            if (busy !== 1'b1) begin n_fail++; $display("FAIL bp_busy got %b expected 1", busy); end
            tick();
        end
        req_valid  = '0;
        resp_ready = 1'b1;
        tick();
    endtask

    task automatic test_reset_mid();
        set_req(2, 8'h3C, 8'h5A, 8'h81);
        req_valid  = 3'b100;
        resp_ready = 1'b1;
        tick();
        req_valid = '0;
        rst_n = 1'b0;
        model_reset();
        #2;
        n_checks += 2;
        if (resp_valid !== 1'b0) begin n_fail++; $display("FAIL rstmid_valid got %b expected 0", resp_valid); end
        if (busy !== 1'b0) begin n_fail++; $display("FAIL rstmid_busy got %b expected 0", busy); end
        rst_n = 1'b1;
        tick();
        for (int cyc = 0; cyc < 3; cyc++) begin
            #1;
            n_checks++;
            if (resp_valid !== 1'b0) begin n_fail++; $display("FAIL rstmid_noresp got %b expected 0", resp_valid); end
            tick();
        end
        req_valid = 3'b111;
        #1;
        n_checks++;
        if (req_ready !== 3'b001) begin n_fail++; $display("FAIL rstmid_first got %b expected 001", req_ready); end
        tick();
        req_valid = '0;
        tick(); tick();
    endtask

    task automatic test_wrap();
        resp_ready = 1'b1;
        req_valid  = 3'b100;
        tick();
        req_valid = '0;
        tick(); tick();
        req_valid = 3'b010;
        #1;
        n_checks++;
        if (req_ready !== 3'b010) begin n_fail++; $display("FAIL wrap_req1 got %b expected 010", req_ready); end
        tick();
        req_valid = '0;
        tick(); tick();
        req_valid = 3'b101;
        #1;
        n_checks++;
        if (req_ready !== 3'b100) begin n_fail++; $display("FAIL wrap_req2_first got %b expected 100", req_ready); end
        tick();
        req_valid = 3'b001;
        tick(); tick();
        #1;
        n_checks++;
        if (req_ready !== 3'b001) begin n_fail++; $display("FAIL wrap_req0_next got %b expected 001", req_ready); end
        tick();
        req_valid = '0;
        tick(); tick();
    endtask

    task automatic test_random();
        do_reset();
        for (int cyc = 0; cyc < 400; cyc++) begin
            req_valid  = 3'($urandom);
            resp_ready = ($urandom_range(0, 9) < 7);
            req_a = 24'($urandom); req_b = 24'($urandom); req_c = 24'($urandom);
            #1;
            model_eval();
            n_checks += 3;
            if (req_ready !== exp_ready) begin n_fail++; $display("FAIL rand_ready got %b expected %b", req_ready, exp_ready); end
            if (resp_valid !== exp_rv) begin n_fail++; $display("FAIL rand_valid got %b expected %b", resp_valid, exp_rv); end
            if (busy !== exp_busy) begin n_fail++; $display("FAIL rand_busy got %b expected %b", busy, exp_busy); end
            if (exp_rv) begin
                n_checks += 3;
                if (resp_d !== m_d) begin n_fail++; $display("FAIL rand_d got %h expected %h", resp_d, m_d); end
                if (resp_e !== m_e) begin n_fail++; $display("FAIL rand_e got %h expected %h", resp_e, m_e); end
                if (resp_id !== 2'(m_id)) begin n_fail++; $display("FAIL rand_id got %0d expected %0d", resp_id, m_id); end
            end
            tick();
        end
    endtask

    initial begin
        model_reset();
        test_reset();
        test_single("single", 0, 8'hFF, 8'hFF, 8'hFF, 8'h00, 8'hFF);
        test_single("mixed", 1, 8'h0F, 8'hFF, 8'hAA, 8'hF0, 8'h5F);
        test_fairness();
        test_backpressure();
        test_reset_mid();
        test_wrap();
        test_random();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
